// File: rtl/alu_issue_if.sv
// Instruction and result stream bundle for the ALU issue stage.
// The master side is the instruction producer and result consumer; the slave side is the stage.
interface alu_issue_if;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic [AW-1:0] res_rd;

   modport master (
      output instr_valid, output instr, input instr_ready,
      input res_valid, input res_data, input res_rd, output res_ready
   );

   modport slave (
      input instr_valid, input instr, output instr_ready,
      output res_valid, output res_data, output res_rd, input res_ready
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a 16-bit ALU: decode, register read with bypass, result capture/writeback.
// Optional macro ALU_FLAGS_EN adds registered zero/negative flags updated on every writeback.
module alu_issue_stage #(
   localparam int unsigned DW    = 16,
   localparam int unsigned AW    = 3,
   localparam int unsigned NREGS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_issue_if.slave    bus,
   output logic [DW-1:0] alu_a_o,
   output logic [DW-1:0] alu_b_o,
   output logic [2:0]    alu_operation_o,
   output logic          alu_operand_o,
   input  logic [DW-1:0] alu_result_i,
   input  logic          rf_we_i,
   input  logic [AW-1:0] rf_waddr_i,
   input  logic [DW-1:0] rf_wdata_i
`ifdef ALU_FLAGS_EN
   ,
   output logic          flag_z_o,
   output logic          flag_n_o
`endif
);

   // State bits are {exec_vld, res_valid}
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      OUT   = 2'b01,
      EXEC  = 2'b10,
      FULL  = 2'b11
   } state_e;

   state_e        state_q, state_d;
   logic          exec_vld, res_vld, adv, instr_ready_c, accept;
   logic [DW-1:0] rf_q [NREGS];
   logic [AW-1:0] rd_q;
   logic [DW-1:0] alu_a_q, alu_b_q, res_data_q;
   logic [2:0]    alu_op_q;
   logic          alu_sel_q;
   logic [AW-1:0] res_rd_q;
   logic [AW-1:0] rd, rs1, rs2;
   logic [DW-1:0] src_a, src_b;

   assign rd  = bus.instr[11:9];
   assign rs1 = bus.instr[8:6];
   assign rs2 = bus.instr[5:3];

   always_comb begin : next_state
      state_d       = state_q;
      exec_vld      = state_q[1];
      res_vld       = state_q[0];
      adv           = exec_vld & (~res_vld | bus.res_ready);
      instr_ready_c = ~exec_vld | adv;
      accept        = bus.instr_valid & instr_ready_c;
      state_d       = state_e'({accept | (exec_vld & ~adv), adv | (res_vld & ~bus.res_ready)});
   end

   // Source read: in-flight writeback beats host load beats the register file
   always_comb begin : bypass
      src_a = rf_q[rs1];
      src_b = rf_q[rs2];
      if (rf_we_i && rf_waddr_i == rs1) src_a = rf_wdata_i;
      if (rf_we_i && rf_waddr_i == rs2) src_b = rf_wdata_i;
      if (adv && rd_q == rs1) src_a = alu_result_i;
      if (adv && rd_q == rs2) src_b = alu_result_i;
   end

   always_ff @(posedge clk) begin : seq
      if (!rst_n) begin
         state_q    <= EMPTY;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         alu_sel_q  <= 1'b0;
         rd_q       <= '0;
         res_data_q <= '0;
         res_rd_q   <= '0;
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_a_q   <= src_a;
            alu_b_q   <= src_b;
            alu_op_q  <= bus.instr[15:13];
            alu_sel_q <= bus.instr[12];
            rd_q      <= rd;
         end
         if (adv) begin
            res_data_q <= alu_result_i;
            res_rd_q   <= rd_q;
         end
         // Writeback wins over a host load to the same register
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (adv && rd_q == AW'(i))
               rf_q[i] <= alu_result_i;
            else if (rf_we_i && rf_waddr_i == AW'(i))
               rf_q[i] <= rf_wdata_i;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic flag_z_q, flag_n_q;

   always_ff @(posedge clk) begin : flags
      if (!rst_n) begin
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else if (adv) begin
         flag_z_q <= (alu_result_i == '0);
         flag_n_q <= alu_result_i[DW-1];
      end
   end

   assign flag_z_o = flag_z_q;
   assign flag_n_o = flag_n_q;
`endif

   assign bus.instr_ready  = instr_ready_c;
   assign bus.res_valid    = state_q[0];
   assign bus.res_data     = res_data_q;
   assign bus.res_rd       = res_rd_q;
   assign alu_a_o          = alu_a_q;
   assign alu_b_o          = alu_b_q;
   assign alu_operation_o  = alu_op_q;
   assign alu_operand_o    = alu_sel_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run against an in-order program model.
// Also checks the ALU_FLAGS_EN flag outputs when that macro is defined.
`timescale 1ns/1ps
module tb_alu_issue_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        alu_sel;
   logic        rf_we = 1'b0;
   logic [2:0]  rf_waddr = '0;
   logic [15:0] rf_wdata = '0;
`ifdef ALU_FLAGS_EN
   logic        flag_z, flag_n;
`endif
   int total = 0;
   int bad = 0;

   alu_issue_if bus();

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_operation_o(alu_op), .alu_operand_o(alu_sel),
      .alu_result_i(alu_result),
      .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata)
`ifdef ALU_FLAGS_EN
      , .flag_z_o(flag_z), .flag_n_o(flag_n)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural ALU sitting downstream of the stage
   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic sel,
                                         input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return sel ? ~a : (a << 1);
         3'd6: return sel ? b : a;
         default: return sel ? (a >> 1) : b;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_sel, alu_a, alu_b);

   function automatic logic [15:0] mk(input logic [2:0] op, input logic sel, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, sel, rd, rs1, rs2, 3'b000};
   endfunction

   task automatic host_load(input logic [2:0] a, input logic [15:0] d);
      rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
      @(negedge clk);
      rf_we = 1'b0;
   endtask

   // Issue one instruction into an idle stage and wait (bounded) for its result
   task automatic issue_wait(input logic [15:0] ins, output logic [15:0] data,
                             output logic [2:0] rd, output bit ok);
      bus.instr_valid = 1'b1; bus.instr = ins; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      for (int i = 0; i < 8 && !bus.res_valid; i++) @(negedge clk);
      ok = bus.res_valid; data = bus.res_data; rd = bus.res_rd;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      logic [15:0] d; logic [2:0] r; bit ok;
      for (int i = 0; i < 8; i++) begin
         issue_wait(mk(3'd6, 1'b0, 3'(i), 3'(i), 3'd0), d, r, ok);
         total++;
         if (!ok || d !== 16'h0) begin
            bad++; $display("FAIL %s_r%0d got=%h ok=%0d exp=0000", tag, i, d, ok);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0; bus.res_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if ({bus.res_valid, alu_a, alu_b, alu_op, alu_sel, bus.res_data, bus.res_rd} !== '0) begin
         bad++; $display("FAIL reset_regs got=%b/%h/%h/%h exp=0", bus.res_valid, alu_a, alu_b, bus.res_data);
      end
      total++;
      if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
      check_all_zero("reset_rf");
   endtask

   task automatic test_host_add();
      logic [15:0] d; logic [2:0] r; bit ok;
      host_load(3'd1, 16'h0005);
      host_load(3'd2, 16'h0007);
      bus.instr_valid = 1'b1; bus.instr = 16'h0650; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      total++;
      if ({alu_a, alu_b, alu_op, alu_sel} !== {16'h5, 16'h7, 3'd0, 1'b0}) begin
         bad++; $display("FAIL add_operands got=%h/%h/%h exp=0005/0007/0", alu_a, alu_b, alu_op);
      end
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.res_data, bus.res_rd} !== {1'b1, 16'h000C, 3'd3}) begin
         bad++; $display("FAIL add_result got=%b/%h/%h exp=1/000c/3", bus.res_valid, bus.res_data, bus.res_rd);
      end
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL add_drop got=%b exp=0", bus.res_valid); end
      // Host load to the source register in the accept cycle is forwarded
      rf_we = 1'b1; rf_waddr = 3'd4; rf_wdata = 16'hABCD;
      bus.instr_valid = 1'b1; bus.instr = mk(3'd6, 1'b0, 3'd4, 3'd4, 3'd0);
      @(negedge clk);
      rf_we = 1'b0; bus.instr_valid = 1'b0;
      total++;
      if (alu_a !== 16'hABCD) begin bad++; $display("FAIL host_bypass got=%h exp=abcd", alu_a); end
      repeat (2) @(negedge clk);
      issue_wait(mk(3'd6, 1'b0, 3'd4, 3'd4, 3'd0), d, r, ok);
      total++;
      if (!ok || d !== 16'hABCD) begin bad++; $display("FAIL host_write_r4 got=%h exp=abcd", d); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d; logic [2:0] r; bit ok;
      host_load(3'd3, 16'hFFFF);
      bus.instr_valid = 1'b1; bus.instr = 16'h0650; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.instr = 16'h28C8;
      rf_we = 1'b1; rf_waddr = 3'd3; rf_wdata = 16'h5555;
      #1;
      total++;
      if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.instr_ready); end
      @(negedge clk);
      bus.instr_valid = 1'b0; rf_we = 1'b0;
      total++;
      if ({alu_a, alu_b, alu_op} !== {16'h000C, 16'h0005, 3'd1}) begin
         bad++; $display("FAIL b2b_bypass got=%h/%h/%h exp=000c/0005/1", alu_a, alu_b, alu_op);
      end
      total++;
      if ({bus.res_valid, bus.res_data, bus.res_rd} !== {1'b1, 16'h000C, 3'd3}) begin
         bad++; $display("FAIL b2b_first got=%b/%h/%h exp=1/000c/3", bus.res_valid, bus.res_data, bus.res_rd);
      end
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.res_data, bus.res_rd} !== {1'b1, 16'h0007, 3'd4}) begin
         bad++; $display("FAIL b2b_second got=%b/%h/%h exp=1/0007/4", bus.res_valid, bus.res_data, bus.res_rd);
      end
      issue_wait(mk(3'd6, 1'b0, 3'd3, 3'd3, 3'd0), d, r, ok);
      total++;
      if (!ok || d !== 16'h000C) begin bad++; $display("FAIL b2b_wb_wins got=%h exp=000c", d); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_d [3] = '{16'h000C, 16'h0002, 16'h0002};
      logic [2:0]  exp_r [3] = '{3'd6, 3'd7, 3'd0};
      bus.res_ready = 1'b0; bus.instr_valid = 1'b1; bus.instr = 16'h0C50;
      @(negedge clk);
      bus.instr = 16'h2E88;
      @(negedge clk);
      bus.instr = 16'h8050;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({bus.instr_ready, bus.res_valid, bus.res_data, bus.res_rd, alu_a, alu_b, alu_op} !==
             {1'b0, 1'b1, 16'h000C, 3'd6, 16'h0007, 16'h0005, 3'd1}) begin
            bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=0/000c/0007/0005", i,
                            bus.instr_ready, bus.res_data, alu_a, alu_b);
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      #1;
      total++;
      if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", bus.instr_ready); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({bus.res_valid, bus.res_data, bus.res_rd} !== {1'b1, exp_d[i], exp_r[i]}) begin
            bad++; $display("FAIL drain%0d got=%b/%h/%h exp=1/%h/%h", i, bus.res_valid, bus.res_data,
                            bus.res_rd, exp_d[i], exp_r[i]);
         end
         @(negedge clk);
         bus.instr_valid = 1'b0;
      end
      total++;
      if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.res_valid); end
   endtask

   task automatic test_collision();
      logic [15:0] d; logic [2:0] r; bit ok;
      bus.res_ready = 1'b1; bus.instr_valid = 1'b1; bus.instr = 16'hBA40;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      rf_we = 1'b1; rf_waddr = 3'd5; rf_wdata = 16'h1234;
      @(negedge clk);
      rf_we = 1'b0;
      total++;
      if ({bus.res_valid, bus.res_data, bus.res_rd} !== {1'b1, 16'hFFFA, 3'd5}) begin
         bad++; $display("FAIL not_result got=%b/%h/%h exp=1/fffa/5", bus.res_valid, bus.res_data, bus.res_rd);
      end
      @(negedge clk);
      issue_wait(mk(3'd6, 1'b0, 3'd0, 3'd5, 3'd0), d, r, ok);
      total++;
      if (!ok || d !== 16'hFFFA) begin bad++; $display("FAIL collision_r5 got=%h exp=fffa", d); end
   endtask

   task automatic test_reset_mid();
      bus.res_ready = 1'b0; bus.instr_valid = 1'b1; bus.instr = 16'h0250;
      repeat (2) @(negedge clk);
      bus.instr_valid = 1'b0;
      #1;
      total++;
      if ({bus.instr_ready, bus.res_valid} !== 2'b01) begin
         bad++; $display("FAIL mid_full got=%b%b exp=01", bus.instr_ready, bus.res_valid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if ({bus.instr_ready, bus.res_valid, alu_a, alu_b, bus.res_data, bus.res_rd} !== {1'b1, 1'b0, 51'h0}) begin
         bad++; $display("FAIL mid_reset got=%b/%b/%h/%h exp=1/0/0/0", bus.instr_ready, bus.res_valid,
                         alu_a, bus.res_data);
      end
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL mid_no_wb got=%b exp=0", bus.res_valid); end
      check_all_zero("mid_rf");
   endtask

`ifdef ALU_FLAGS_EN
   task automatic test_flags();
      logic [15:0] d; logic [2:0] r; bit ok;
      host_load(3'd1, 16'h0005);
      issue_wait(16'h2448, d, r, ok);
      total++;
      if ({ok, d, flag_z, flag_n} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL flags_sub got=%h z=%b n=%b exp=0000 z=1 n=0", d, flag_z, flag_n);
      end
      issue_wait(16'hB440, d, r, ok);
      total++;
      if ({ok, d, flag_z, flag_n} !== {1'b1, 16'hFFFA, 1'b0, 1'b1}) begin
         bad++; $display("FAIL flags_not got=%h z=%b n=%b exp=fffa z=0 n=1", d, flag_z, flag_n);
      end
   endtask
`endif

   task automatic test_random();
      logic [15:0] mrf [8];
      logic [18:0] expq [$];
      logic [18:0] got, e;
      logic [15:0] ins, res;
      bit          stalled = 1'b0;
      logic [18:0] prev = '0;
      bit          exp_ready;
      rst_n = 1'b0; bus.instr_valid = 1'b0; bus.res_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mrf[i] = 16'($urandom);
         host_load(3'(i), mrf[i]);
      end
      for (int cyc = 0; cyc < 500; cyc++) begin
         bus.instr_valid = ($urandom_range(0, 9) < 7);
         bus.instr       = 16'($urandom);
         bus.res_ready   = ($urandom_range(0, 9) < 6);
         #1;
         got = {bus.res_rd, bus.res_data};
         if (stalled) begin
            total++;
            if (!bus.res_valid || got !== prev) begin
               bad++; $display("FAIL rnd_stall cyc=%0d got=%h exp=%h", cyc, got, prev);
            end
         end
         exp_ready = !(expq.size() == 2 && !bus.res_ready);
         total++;
         if (bus.instr_ready !== exp_ready) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.instr_ready, exp_ready);
         end
         if (bus.res_valid && bus.res_ready) begin
            total++;
            if (expq.size() == 0) begin
               bad++; $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", cyc, got);
            end else begin
               e = expq.pop_front();
               if (got !== e) begin bad++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, got, e); end
            end
         end
         if (bus.instr_valid && bus.instr_ready) begin
            ins = bus.instr;
            res = alu_f(ins[15:13], ins[12], mrf[ins[8:6]], mrf[ins[5:3]]);
            mrf[ins[11:9]] = res;
            expq.push_back({ins[11:9], res});
         end
         stalled = bus.res_valid && !bus.res_ready;
         prev = got;
         @(negedge clk);
      end
      bus.instr_valid = 1'b0; bus.res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus.res_valid) begin
            got = {bus.res_rd, bus.res_data};
            total++;
            e = (expq.size() != 0) ? expq.pop_front() : 19'h7FFFF;
            if (got !== e) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", got, e); end
         end
         @(negedge clk);
      end
      total++;
      if (expq.size() != 0 || bus.res_valid !== 1'b0) begin
         bad++; $display("FAIL rnd_leftover got=%0d exp=0", expq.size());
      end
   endtask

   initial begin
      bus.instr_valid = 1'b0; bus.instr = '0; bus.res_ready = 1'b0;
      test_reset();
      test_host_add();
      test_back_to_back();
      test_backpressure();
      test_collision();
      test_reset_mid();
`ifdef ALU_FLAGS_EN
      test_flags();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
